// File: rtl/uart_frame_pkg.sv
// Shared definitions for the framed UART receiver: FSM state encoding and
// CRC-16/CCITT-FALSE constants.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CRC_HI  = 2'd2,
    CRC_LO  = 2'd3
  } state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/uart_frame_crc16.sv
// Combinational single-byte CRC-16/CCITT-FALSE step (MSB first, no reflection).
module uart_frame_crc16
  import uart_frame_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] crc_work;

  always_comb begin
    crc_work = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (crc_work[15]) begin
        crc_work = {crc_work[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_work = {crc_work[14:0], 1'b0};
      end
    end
    crc_out = crc_work;
  end

endmodule

// File: rtl/uart_frame_rx.sv
// Byte-stream frame receiver: hunts for a 4-byte sync word, collects a fixed
// payload, checks a trailing CRC-16 and publishes good payloads atomically.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int          PAYLOAD_BYTES  = 16,
  parameter logic [31:0] HEADER         = 32'hDABBAD00,
  parameter int          TIMEOUT_CYCLES = 16000
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic                       rx_data_ready,
  input  logic [7:0]                 rx_data,
  output logic [8*PAYLOAD_BYTES-1:0] payload,
  output logic                       frame_valid,
  output logic                       crc_error,
  output logic                       timeout_error,
  output logic [15:0]                frame_count
);

  localparam int IDX_W = $clog2(PAYLOAD_BYTES + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW    = 8 * PAYLOAD_BYTES;

  state_t             state_reg, state_next;
  logic [31:0]        window_reg, window_next;
  logic [IDX_W-1:0]   index_reg, index_next;
  logic [15:0]        crc_reg, crc_next;
  logic [7:0]         crc_hi_reg, crc_hi_next;
  logic [TMR_W-1:0]   timer_reg, timer_next;
  logic [PW-1:0]      staging_reg, staging_next;
  logic [PW-1:0]      payload_reg, payload_next;
  logic [15:0]        frame_count_reg, frame_count_next;
  logic               frame_valid_reg, frame_valid_next;
  logic               crc_error_reg, crc_error_next;
  logic               timeout_error_reg, timeout_error_next;

  logic [15:0]        crc_step;
  logic [31:0]        window_shift;
  logic               timed_out;

  uart_frame_crc16 u_crc (
    .crc_in  (crc_reg),
    .data    (rx_data),
    .crc_out (crc_step)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_reg         <= HUNT;
      window_reg        <= '0;
      index_reg         <= '0;
      crc_reg           <= CRC_INIT;
      crc_hi_reg        <= '0;
      timer_reg         <= '0;
      staging_reg       <= '0;
      payload_reg       <= '0;
      frame_count_reg   <= '0;
      frame_valid_reg   <= 1'b0;
      crc_error_reg     <= 1'b0;
      timeout_error_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      window_reg        <= window_next;
      index_reg         <= index_next;
      crc_reg           <= crc_next;
      crc_hi_reg        <= crc_hi_next;
      timer_reg         <= timer_next;
      staging_reg       <= staging_next;
      payload_reg       <= payload_next;
      frame_count_reg   <= frame_count_next;
      frame_valid_reg   <= frame_valid_next;
      crc_error_reg     <= crc_error_next;
      timeout_error_reg <= timeout_error_next;
    end
  end

  assign window_shift = {window_reg[23:0], rx_data};
  // A byte landing in the cycle the gap reaches the limit wins over the timeout.
  assign timed_out = (state_reg != HUNT) && !rx_data_ready &&
                     (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next         = state_reg;
    window_next        = window_reg;
    index_next         = index_reg;
    crc_next           = crc_reg;
    crc_hi_next        = crc_hi_reg;
    staging_next       = staging_reg;
    payload_next       = payload_reg;
    frame_count_next   = frame_count_reg;
    frame_valid_next   = 1'b0;
    crc_error_next     = 1'b0;
    timeout_error_next = 1'b0;

    if (state_reg == HUNT || rx_data_ready) begin
      timer_next = '0;
    end else begin
      timer_next = timer_reg + 1'b1;
    end

    if (timed_out) begin
      state_next         = HUNT;
      window_next        = '0;
      index_next         = '0;
      crc_next           = CRC_INIT;
      staging_next       = '0;
      timer_next         = '0;
      timeout_error_next = 1'b1;
    end else if (rx_data_ready) begin
      unique case (state_reg)
        HUNT: begin
          if (window_shift == HEADER) begin
            state_next  = PAYLOAD;
            window_next = '0;
            index_next  = '0;
            crc_next    = CRC_INIT;
          end else begin
            window_next = window_shift;
          end
        end
        PAYLOAD: begin
          for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (index_reg == IDX_W'(i)) begin
              staging_next[8*i +: 8] = rx_data;
            end
          end
          crc_next   = crc_step;
          index_next = index_reg + 1'b1;
          if (index_reg == IDX_W'(PAYLOAD_BYTES - 1)) begin
            state_next = CRC_HI;
          end
        end
        CRC_HI: begin
          crc_hi_next = rx_data;
          state_next  = CRC_LO;
        end
        CRC_LO: begin
          state_next = HUNT;
          if ({crc_hi_reg, rx_data} == crc_reg) begin
            payload_next     = staging_reg;
            frame_count_next = frame_count_reg + 16'd1;
            frame_valid_next = 1'b1;
          end else begin
            crc_error_next = 1'b1;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  assign payload       = payload_reg;
  assign frame_valid   = frame_valid_reg;
  assign crc_error     = crc_error_reg;
  assign timeout_error = timeout_error_reg;
  assign frame_count   = frame_count_reg;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: stimulus queues expected events, a
// monitor pops and compares whenever the receiver pulses an output.
module tb_uart_frame_rx;

  localparam int PB = 9;
  localparam int T  = 40;
  localparam int PW = 8 * PB;

  typedef logic [7:0] bytes_t[$];
  typedef enum int {EV_VALID, EV_CRCERR, EV_TIMEOUT} ev_kind_t;
  typedef struct {
    ev_kind_t      kind;
    logic [PW-1:0] pl;
    logic [15:0]   cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_data_ready = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic [PW-1:0] payload;
  logic          frame_valid;
  logic          crc_error;
  logic          timeout_error;
  logic [15:0]   frame_count;

  int vectors = 0;
  int miscompares = 0;
  exp_t exp_q[$];
  logic [PW-1:0] exp_payload = '0;
  logic [15:0]   exp_count = '0;

  uart_frame_rx #(
    .PAYLOAD_BYTES  (PB),
    .HEADER         (32'hDABBAD00),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .CLK           (clk),
    .rst           (rst),
    .rx_data_ready (rx_data_ready),
    .rx_data       (rx_data),
    .payload       (payload),
    .frame_valid   (frame_valid),
    .crc_error     (crc_error),
    .timeout_error (timeout_error),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (frame_valid || crc_error || timeout_error)) begin
      ev_kind_t act;
      exp_t e;
      int npulse;
      npulse = int'(frame_valid) + int'(crc_error) + int'(timeout_error);
      act = frame_valid ? EV_VALID : (crc_error ? EV_CRCERR : EV_TIMEOUT);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: got %s count=%h, required no pulse", act.name(), frame_count);
      end else begin
        e = exp_q.pop_front();
        if (npulse != 1 || act != e.kind || payload !== e.pl || frame_count !== e.cnt) begin
          miscompares++;
          $display("FAIL event: got %s (pulses=%0d) payload=%h count=%h, required %s payload=%h count=%h",
                   act.name(), npulse, payload, frame_count, e.kind.name(), e.pl, e.cnt);
        end else begin
          $display("event %s payload=%h count=%h ok", act.name(), payload, frame_count);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  function automatic logic [PW-1:0] pack(input bytes_t p);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < p.size(); i++) r[8*i +: 8] = p[i];
    return r;
  endfunction

  // Bit-serial reference CRC-16/CCITT-FALSE.
  function automatic logic [15:0] crc_model(input bytes_t p);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 0; i < p.size(); i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ p[i][b];
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rx_data_ready = 1'b0;
      rx_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    idle(gap);
    rx_data_ready = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1;
    rx_data_ready = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic send_seq(input bytes_t s, input int gap);
    for (int i = 0; i < s.size(); i++) send_byte(s[i], gap);
  endtask

  task automatic send_frame(input bytes_t pre, input bytes_t pl, input logic [15:0] crc, input int gap);
    send_seq(pre, 0);
    send_seq(pl, gap);
    send_byte(crc[15:8], gap);
    send_byte(crc[7:0], gap);
  endtask

  task automatic expect_ev(input ev_kind_t k);
    exp_t e;
    e.kind = k;
    e.pl   = exp_payload;
    e.cnt  = exp_count;
    exp_q.push_back(e);
  endtask

  task automatic expect_good(input bytes_t pl);
    exp_payload = pack(pl);
    exp_count   = exp_count + 16'd1;
    expect_ev(EV_VALID);
  endtask

  initial begin
    bytes_t hdr, pa, pb, garbage;
    logic [15:0] crc_b;
    int waited;
    hdr     = '{8'hDA, 8'hBB, 8'hAD, 8'h00};
    pa      = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    pb      = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h80, 8'h7E};
    garbage = '{8'h11, 8'hDA, 8'hDA, 8'hBB, 8'hAD, 8'h00};
    crc_b   = crc_model(pb);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_payload", 80'(payload), 80'(0));
    chk("reset_frame_count", 80'(frame_count), 80'(0));
    chk("reset_pulses", 80'({frame_valid, crc_error, timeout_error}), 80'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    chk("idle_pulses", 80'({frame_valid, crc_error, timeout_error}), 80'(0));

    // Known CRC vector "123456789" -> 29B1
    expect_good(pa);
    send_frame(hdr, pa, 16'h29B1, 0);
    idle(2);
    chk("ascii_payload", 80'(payload), 80'(72'h393837363534333231));
    chk("ascii_count", 80'(frame_count), 80'(1));

    // Corrupted CRC low byte
    expect_ev(EV_CRCERR);
    send_frame(hdr, pa, 16'h29B2, 1);
    idle(2);

    // Overlapping sync prefix
    expect_good(pb);
    send_frame(garbage, pb, crc_b, 0);
    idle(2);

    // Stall after three payload bytes
    expect_ev(EV_TIMEOUT);
    send_seq(hdr, 0);
    for (int i = 0; i < 3; i++) send_byte(pa[i], 0);
    idle(T + 5);
    expect_good(pa);
    send_frame(hdr, pa, 16'h29B1, 0);
    idle(2);

    // Every byte arrives exactly at the timeout limit
    expect_good(pb);
    send_frame(hdr, pb, crc_b, T - 1);
    idle(2);

    // One cycle over the limit mid-payload
    expect_ev(EV_TIMEOUT);
    send_seq(hdr, 0);
    for (int i = 0; i < 4; i++) send_byte(pa[i], 0);
    send_byte(8'h55, T);
    expect_good(pa);
    send_frame(hdr, pa, 16'h29B1, 0);
    idle(2);

    // Reset mid-frame drops the partial frame silently
    send_seq(hdr, 0);
    for (int i = 0; i < 5; i++) send_byte(pb[i], 0);
    rst = 1'b1;
    exp_payload = '0;
    exp_count   = '0;
    @(negedge clk);
    chk("midreset_payload", 80'(payload), 80'(0));
    chk("midreset_count", 80'(frame_count), 80'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    expect_good(pa);
    send_frame(hdr, pa, 16'h29B1, 0);
    idle(T + 5);

    // Frame counter wrap
    force dut.frame_count_reg = 16'hFFFF;
    @(posedge clk);
    #1 release dut.frame_count_reg;
    idle(2);
    chk("preload_count", 80'(frame_count), 80'(16'hFFFF));
    exp_count = 16'hFFFF;
    expect_good(pb);
    send_frame(hdr, pb, crc_b, 0);

    // Drain scoreboard
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    idle(2);
    chk("scoreboard_drained", 80'(exp_q.size()), 80'(0));
    chk("final_count", 80'(frame_count), 80'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
